// File: rtl/ct_mat_lsu_ex2_agu.sv
//------------------------------------------------------------------------------
// ct_mat_lsu_ex2_agu
//
// Purpose:
//   Matrix load/store address generation unit (EX2 stage). It accepts one
//   matrix load/store instruction from EX1. It then emits one memory request
//   per matrix row, stepping the address by the row stride. After the last
//   row it reports completion for one cycle.
//
// Ports:
//   forever_cpuclk        clock
//   cpurst_b              asynchronous active-low reset
//   rtu_yy_xx_flush       pipeline flush; kills the instruction in flight
//   ex1_agu_*             EX1 instruction: valid, iid, optype, base, stride
//   x_sizeM / x_sizeK     rows / elements per row of the instruction
//   agu_ex1_ready         block is idle and can take an instruction
//   agu_mem_req_*         per-row memory request (valid/ready handshake)
//   mem_agu_req_rdy       memory accepts the current request
//   agu_cmplt_vld/_iid    one-cycle completion pulse with instruction id
//   agu_busy              an instruction is in progress
//------------------------------------------------------------------------------
module ct_mat_lsu_ex2_agu #(
    parameter logic [1:0] MAT_LSU_LOAD  = 2'b01,
    parameter logic [1:0] MAT_LSU_STORE = 2'b10
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        rtu_yy_xx_flush,
    input  logic        ex1_agu_vld,
    input  logic [6:0]  ex1_agu_iid,
    input  logic [1:0]  ex1_agu_optype,
    input  logic [63:0] ex1_agu_base,
    input  logic        ex1_agu_stride_vld,
    input  logic [63:0] ex1_agu_stride,
    input  logic [1:0]  ex1_agu_elem_width,
    input  logic [7:0]  x_sizeM,
    input  logic [15:0] x_sizeK,
    output logic        agu_ex1_ready,
    output logic        agu_mem_req_vld,
    input  logic        mem_agu_req_rdy,
    output logic [63:0] agu_mem_req_addr,
    output logic [18:0] agu_mem_req_len,
    output logic [7:0]  agu_mem_req_row,
    output logic        agu_mem_req_st,
    output logic [6:0]  agu_mem_req_iid,
    output logic        agu_mem_req_last,
    output logic        agu_cmplt_vld,
    output logic [6:0]  agu_cmplt_iid,
    output logic        agu_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_CMPLT = 2'd2;

    // Latched instruction and walking state
    logic [1:0]  r_state;
    logic [6:0]  r_iid;
    logic [1:0]  r_optype;
    logic [1:0]  r_elem_width;
    logic [7:0]  r_size_m;
    logic [15:0] r_size_k;
    logic [63:0] r_stride;
    logic [7:0]  r_row;
    logic [63:0] r_addr;

    logic [1:0]  w_next_state;
    logic [18:0] w_row_bytes;
    logic [18:0] w_lat_row_bytes;
    logic [63:0] w_stride_eff;
    logic        w_accept;
    logic        w_size_zero;
    logic        w_last;
    logic        w_req_vld;
    logic        w_handshake;

    // Row bytes: K is at most 16 bits and the shift at most 3, so 19 bits
    // always hold the result exactly.
    assign w_row_bytes     = {3'b000, x_sizeK} << ex1_agu_elem_width;
    assign w_lat_row_bytes = {3'b000, r_size_k} << r_elem_width;

    // Without an explicit stride the rows are packed back to back.
    assign w_stride_eff = ex1_agu_stride_vld ? ex1_agu_stride
                                             : {45'd0, w_row_bytes};

    assign w_accept    = (r_state == ST_IDLE) & ex1_agu_vld & ~rtu_yy_xx_flush;
    assign w_size_zero = (x_sizeM == 8'd0) | (x_sizeK == 16'd0);
    assign w_last      = (r_row == (r_size_m - 8'd1));

    // Flush gates the valids combinationally so nothing escapes in that cycle.
    assign w_req_vld   = (r_state == ST_REQ) & ~rtu_yy_xx_flush;
    assign w_handshake = w_req_vld & mem_agu_req_rdy;

    // State register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush returns to IDLE from every state
    always_comb begin
        w_next_state = r_state;
        if (rtu_yy_xx_flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex1_agu_vld) begin
                        w_next_state = w_size_zero ? ST_CMPLT : ST_REQ;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (w_handshake && w_last) begin
                        w_next_state = ST_CMPLT;
                    end else begin
                        w_next_state = ST_REQ;
                    end
                end
                ST_CMPLT: begin
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Instruction latch on accept; row/address walk on each accepted request
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_iid        <= 7'd0;
            r_optype     <= 2'd0;
            r_elem_width <= 2'd0;
            r_size_m     <= 8'd0;
            r_size_k     <= 16'd0;
            r_stride     <= 64'd0;
            r_row        <= 8'd0;
            r_addr       <= 64'd0;
        end else if (w_accept) begin
            r_iid        <= ex1_agu_iid;
            r_optype     <= ex1_agu_optype;
            r_elem_width <= ex1_agu_elem_width;
            r_size_m     <= x_sizeM;
            r_size_k     <= x_sizeK;
            r_stride     <= w_stride_eff;
            r_row        <= 8'd0;
            r_addr       <= ex1_agu_base;
        end else if (w_handshake && !w_last) begin
            r_row  <= r_row + 8'd1;
            // Address wraps modulo 2^64 by construction.
            r_addr <= r_addr + r_stride;
        end
    end

    // Output decode from the current state and latched payload
    always_comb begin
        agu_ex1_ready    = (r_state == ST_IDLE);
        agu_busy         = (r_state != ST_IDLE);
        agu_mem_req_vld  = w_req_vld;
        agu_mem_req_addr = r_addr;
        agu_mem_req_len  = w_lat_row_bytes;
        agu_mem_req_row  = r_row;
        agu_mem_req_st   = (r_optype == MAT_LSU_STORE);
        agu_mem_req_iid  = r_iid;
        agu_mem_req_last = (r_state == ST_REQ) & w_last;
        agu_cmplt_vld    = (r_state == ST_CMPLT) & ~rtu_yy_xx_flush;
        agu_cmplt_iid    = r_iid;
    end

endmodule

// File: doc/ct_mat_lsu_ex2_agu.md
CT_MAT_LSU_EX2_AGU -- requirements
Module: ct_mat_lsu_ex2_agu

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: forever_cpuclk is the clock, cpurst_b is the reset, and all state is reset asynchronously on cpurst_b low.
REQ-002 Parameter: MAT_LSU_LOAD, default 2'b01, load optype encoding.
REQ-003 Parameter: MAT_LSU_STORE, default 2'b10, store optype encoding.
REQ-004 forever_cpuclk  in  1  clock.
REQ-005 cpurst_b  in  1  async active-low reset.
REQ-006 rtu_yy_xx_flush  in  1  pipeline flush.
REQ-007 ex1_agu_vld  in  1  EX1 load/store instruction valid.
REQ-008 ex1_agu_iid  in  7  instruction id.
REQ-009 ex1_agu_optype  in  2  load or store encoding.
REQ-010 ex1_agu_base  in  64  base address (src0).
REQ-011 ex1_agu_stride_vld  in  1  explicit stride present.
REQ-012 ex1_agu_stride  in  64  row stride in bytes (src1).
REQ-013 ex1_agu_elem_width  in  2  element size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-014 x_sizeM  in  8  row count; x_sizeK  in  16  elements per row.
REQ-015 agu_ex1_ready  out  1  block can accept an instruction.
REQ-016 agu_mem_req_vld  out  1  row request valid.
REQ-017 mem_agu_req_rdy  in  1  memory accepts the request.
REQ-018 Request payload outputs: agu_mem_req_addr  out  64; agu_mem_req_len  out  19 (bytes); agu_mem_req_row  out  8; agu_mem_req_st  out  1; agu_mem_req_iid  out  7; agu_mem_req_last  out  1.
REQ-019 Completion outputs: agu_cmplt_vld  out  1; agu_cmplt_iid  out  7.
REQ-020 agu_busy  out  1  state is not IDLE.

Function
REQ-021 SHALL implement an FSM with states IDLE, REQ and CMPLT.
REQ-022 agu_ex1_ready SHALL be 1 iff the state is IDLE.
REQ-023 Accept SHALL occur when the state is IDLE, ex1_agu_vld=1 and rtu_yy_xx_flush=0.
REQ-024 On accept, the block SHALL latch iid, optype, base, elem_width, x_sizeM, x_sizeK and the effective stride; later changes to the size inputs SHALL have no effect on the latched instruction.
REQ-025 Row bytes SHALL equal x_sizeK << elem_width, held as 19 bits with no overflow.
REQ-026 Effective stride SHALL be ex1_agu_stride when ex1_agu_stride_vld=1, otherwise row bytes zero-extended to 64 bits.
REQ-027 On accept, the next state SHALL be CMPLT if x_sizeM==0 or x_sizeK==0, otherwise REQ, with row=0 and addr=base.
REQ-028 In REQ, agu_mem_req_vld SHALL be 1, with addr = current address, len = row bytes, row = current row, st = (optype==MAT_LSU_STORE), iid = latched iid, and last = (row==sizeM-1).
REQ-029 Handshake: the payload SHALL be held stable while vld=1 and rdy=0, and a row advances only when vld&rdy.
REQ-030 On handshake with last=0: row+1, and addr+stride modulo 2^64 (wrap, no error).
REQ-031 On handshake with last=1, the next state SHALL be CMPLT.
REQ-032 CMPLT SHALL last exactly one cycle, with agu_cmplt_vld=1 and agu_cmplt_iid = latched iid; the next state SHALL be IDLE.
REQ-033 Latency: first request 1 cycle after accept; with rdy tied to 1, cmplt asserts M+1 cycles after accept.
REQ-034 Zero-size instructions: cmplt asserts 1 cycle after accept and no request is issued.
REQ-035 Back-to-back: a new accept SHALL be possible in the cycle after CMPLT, when the state is IDLE.
REQ-036 Flush: when rtu_yy_xx_flush=1, agu_mem_req_vld and agu_cmplt_vld SHALL be forced to 0 in the same cycle (combinational gating), and the next state SHALL be IDLE from any state.
REQ-037 Flush and ex1_agu_vld in the same cycle: the instruction SHALL NOT be accepted.

Reset
REQ-038 While cpurst_b=0: state=IDLE; all payload registers 0; agu_mem_req_vld=0; agu_cmplt_vld=0; agu_busy=0; agu_ex1_ready=1.
REQ-039 Reset asserted mid-instruction SHALL abort it immediately with no completion; after release the block is in IDLE.

Verification
REQ-040 Load, M=3, K=4, elem_width=2, base=0x1000, stride_vld=0, rdy=1 -> requests at 0x1000, 0x1010 and 0x1020 with len=16 and last on row 2; cmplt 4 cycles after accept.
REQ-041 Store, M=2, K=1, elem_width=3, stride=0x100, stride_vld=1, with rdy low for 3 cycles on row 0 -> payload stable throughout the stall; requests at base and base+0x100; st=1.
REQ-042 M=0 -> no agu_mem_req_vld pulse; cmplt one cycle after accept with the correct iid.
REQ-043 Flush in REQ after 1 of 4 rows -> vld=0 the same cycle, IDLE next cycle, no cmplt; the next instruction is accepted normally.
REQ-044 base=0xFFFF_FFFF_FFFF_FFF0, stride=0x20, M=2 -> second address 0x10 (wrap).
REQ-045 cpurst_b asserted during REQ -> all outputs take reset values asynchronously; ready=1 after release.
